// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: one 16-bit Fibonacci LFSR shared by NREQ requesters
// through a round-robin arbiter. Each granted request advances the LFSR
// STEPS times, then delivers the fresh word with a one-hot grant pulse.
//
// Optional build macro: LFSR_RESEED_EN adds the seed_valid / seed_data /
// seed_ready reseed port. Without it the LFSR is loaded only by reset.
//
// Handshake: a requester raises req[i] and holds it until gnt[i] pulses.
// gnt is a single-cycle pulse; rnd_valid equals (gnt != 0), and rnd_data
// is meaningful only in that cycle (forced to zero otherwise). Reseed is a
// valid/ready transfer: seed_data is taken on an edge where seed_valid and
// seed_ready are both high.
module lfsr_rng_arbiter #(
   parameter int          NREQ  = 4,
   parameter int          STEPS = 1,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic            rnd_valid,
   output logic [15:0]     rnd_data,
   output logic            busy,
`ifdef LFSR_RESEED_EN
   input  logic            seed_valid,
   input  logic [15:0]     seed_data,
   output logic            seed_ready,
`endif
   output logic [1:0]      o_dbg_state
);

   localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);
   localparam logic [3:0]      CNT_INIT = 4'(STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STEP    = 2'd1,
      ST_DELIVER = 2'd2
   } state_t;

   state_t        r_state;
   logic [15:0]   r_lfsr;
   logic [PW-1:0] r_rr_ptr;
   logic [PW-1:0] r_winner;
   logic [3:0]    r_cnt;

   logic [PW-1:0] w_win;
   logic          w_any_req;
   logic          w_reseed;
   logic [15:0]   w_seed_value;

   // One LFSR shift: x^16+x^14+x^13+x^11+1, new bit enters at the top.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

`ifdef LFSR_RESEED_EN
   // The all-zero state would lock the LFSR, so a zero seed falls back to SEED.
   assign w_reseed     = seed_valid;
   assign w_seed_value = (seed_data == 16'h0000) ? SEED : seed_data;
   assign seed_ready   = (r_state == ST_IDLE);
`else
   assign w_reseed     = 1'b0;
   assign w_seed_value = SEED;
`endif

   // Round-robin search: first set req bit from r_rr_ptr upward, wrapping.
   always_comb begin
      int j;
      w_win     = '0;
      w_any_req = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(r_rr_ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!w_any_req && req[j]) begin
            w_win     = PW'(j);
            w_any_req = 1'b1;
         end
      end
   end

   // Arbitration FSM; the LFSR advances only in STEP and never free-runs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_lfsr   <= SEED;
         r_rr_ptr <= '0;
         r_winner <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_reseed) begin
                  // Reseed wins over arbitration; requests wait one cycle.
                  r_lfsr <= w_seed_value;
               end else if (w_any_req) begin
                  r_winner <= w_win;
                  r_cnt    <= CNT_INIT;
                  r_state  <= ST_STEP;
               end
            end
            ST_STEP: begin
               r_lfsr <= lfsr_next(r_lfsr);
               if (r_cnt == 4'd0) begin
                  r_state <= ST_DELIVER;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_DELIVER: begin
               r_rr_ptr <= (r_winner == LAST_IDX) ? '0 : r_winner + 1'b1;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Delivery outputs decoded from the registered state.
   always_comb begin
      gnt = '0;
      if (r_state == ST_DELIVER) gnt[r_winner] = 1'b1;
   end

   assign rnd_valid   = (r_state == ST_DELIVER);
   assign rnd_data    = rnd_valid ? r_lfsr : 16'h0000;
   assign busy        = (r_state != ST_IDLE);
   assign o_dbg_state = r_state;

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
- Owns one 16-bit Fibonacci LFSR and shares it among NREQ requesters.
- Uses round-robin arbitration.
- For each granted request, it advances the LFSR STEPS times and delivers the fresh value on a shared data bus with a one-hot grant pulse.
- Sits between the random-number resource and pipeline or peripheral clients that need random words.

Parameters:
- NREQ, 4: number of requesters (2..8).
- STEPS, 1: LFSR shifts per delivered word (1..15).
- SEED, 16'hACE1: reset/default LFSR state; must be nonzero.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level; held until own gnt bit pulses.
- gnt  output  NREQ  one-hot grant, single-cycle pulse; rnd_data is valid in that cycle.
- rnd_valid  output  1  high exactly when gnt is nonzero.
- rnd_data  output  16  delivered random word; 16'h0 when rnd_valid=0.
- busy  output  1  high in STEP and DELIVER.
- seed_valid  input  1  (LFSR_RESEED_EN only) reseed request.
- seed_data  input  16  (LFSR_RESEED_EN only) new seed.
- seed_ready  output  1  (LFSR_RESEED_EN only) high in IDLE.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- LFSR step: fb = s[0]^s[2]^s[3]^s[5]; s_next = {fb, s[15:1]}. Taps are x^16+x^14+x^13+x^11+1.
  - A step takes effect in the same edge, with no one-cycle feedback lag.
  - Sequence from ACE1: ACE1, 5670, AB38, 559C, 2ACE.
- LFSR advances only in STEP state. It never free-runs.
- Reset, at any state including mid-operation, sets:
  - state=IDLE, lfsr=SEED, rr_ptr=0, cnt=0, winner=0;
  - gnt=0, rnd_valid=0, rnd_data=0, busy=0.
  - A request pending when reset was asserted gets no grant and must be re-arbitrated.
- Round-robin: winner = first set bit of req searching from index rr_ptr upward, wrapping modulo NREQ.
- FSM, states IDLE, STEP, DELIVER:
  - IDLE: if req!=0 (and no accepted reseed), the edge latches winner, sets cnt=STEPS-1 and goes to STEP. Otherwise stay.
  - STEP: each edge advances the LFSR once. If cnt==0, go to DELIVER; else cnt--.
  - DELIVER: combinational outputs gnt[winner]=1, rnd_valid=1, rnd_data=lfsr. The edge sets rr_ptr=(winner+1) mod NREQ and goes to IDLE.
- Latency:
  - req seen high in IDLE at edge E gives gnt high in the cycle after edge E+STEPS.
  - That is STEPS+1 cycles from req to gnt; one grant per STEPS+2 cycles under continuous load.
- Boundary conditions:
  - A requester dropping req after being latched does not cancel its grant; the pulse still occurs.
  - req changes during STEP/DELIVER are ignored until the next IDLE.
  - The winner's own req still high in the following IDLE has lowest priority, because rr_ptr has moved past it.
  - All req bits high: grants rotate 0,1,..,NREQ-1,0.
  - rr_ptr wraps from NREQ-1 to 0.
- gnt is never multi-hot. rnd_data is never nonzero without rnd_valid.

Optional Feature:
- Macro: LFSR_RESEED_EN.
- Defined: seed_valid, seed_data and seed_ready ports exist.
  - In IDLE, seed_valid=1 loads lfsr=seed_data at the edge, or SEED if seed_data==0, because the all-zero lock-up state is forbidden.
  - Reseed has priority over req in the same IDLE cycle; arbitration waits one cycle. rr_ptr is unchanged.
  - seed_valid outside IDLE is ignored (seed_ready=0).
- Undefined: the ports are absent; the LFSR is loaded only by reset with SEED.

Test Plan:
- Reset, then req=4'b0001 held → gnt=0001 and rnd_valid=1 two cycles after the first IDLE sampling edge, rnd_data=16'h5670; following cycle gnt=0, busy=0.
- req=4'b1111 held continuously → grants in order 0001,0010,0100,1000 with rnd_data 5670, AB38, 559C, 2ACE, one grant every 3 cycles; no multi-hot gnt.
- STEPS=3 build, req=4'b0100 → gnt=0100 four cycles after sampling, rnd_data=16'h559C.
- Assert reset during STEP → no gnt pulse, outputs 0; after release, req=0010 → gnt=0010 with rnd_data=16'h5670 (rr_ptr back to 0, LFSR reseeded to ACE1).
- req=4'b1000 for one cycle only, then 0 → gnt=1000 still pulses with 5670; next req=4'b1001 → gnt=0001, since rr_ptr wrapped to 0.
- LFSR_RESEED_EN: seed_data=0x0000 with seed_valid in IDLE → next grant rnd_data=5670. seed_data=0x0001 → next grant 0x8000. Reseed and req in the same cycle → reseed taken first, grant one cycle later.
